audio_i2s_tx: RTL and testbench

//  Downstream of radio_core: takes the 16-bit signed demodulated audio (updated on clk_a) and

---
 rtl/audio_i2s_tx.sv | 151 +++++++++++++++
 tb/tb_audio_i2s_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// Mono-duplicated I2S transmitter: syncs clk_a, queues samples in a small FIFO, serialises per frame.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (MSB on the lrclk edge) instead of Philips I2S.
module audio_i2s_tx #(
  parameter int HALF_DIV    = 59,
  parameter int SLOT_BITS   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_s,
  input  logic        reset_n,
  input  logic        clk_a,
  input  logic [15:0] demodulated,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        overflow,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int DW = $clog2(HALF_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(HALF_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [BW-1:0] B_MAX   = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic [BW-1:0] SLOT    = BW'(SLOT_BITS);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_prev_q, edge_prev_d;
  logic [15:0]            mem_q [FIFO_DEPTH];
  logic [15:0]            mem_d [FIFO_DEPTH];
  logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW-1:0]          div_q, div_d;
  logic [BW-1:0]          b_q, b_d;
  logic [15:0]            held_q, held_d;
  logic                   bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;

  logic          push_req, falling, frame_start, pop, fifo_empty, fifo_full;
  logic [BW-1:0] k;

  assign push_req   = sync_q[SYNC_STAGES-1] & ~edge_prev_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_a};
    edge_prev_d = sync_q[SYNC_STAGES-1];
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    div_d       = div_q;
    bclk_d      = bclk_q;
    b_d         = b_q;
    held_d      = held_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    falling     = 1'b0;
    frame_start = 1'b0;
    pop         = 1'b0;
    k           = '0;

    if (div_q == DIV_MAX) begin
      div_d   = '0;
      bclk_d  = ~bclk_q;
      falling = bclk_q;
    end else begin
      div_d = div_q + DIV_ONE;
    end

    if (falling) begin
      frame_start = (b_q == B_MAX);
      b_d         = frame_start ? '0 : b_q + B_ONE;
    end

    // Pop decision uses the pre-push FIFO state.
    if (frame_start) begin
      if (!fifo_empty) pop = 1'b1;
      else             unf_d = 1'b1;
    end
    if (pop) begin
      held_d = mem_q[rptr_q[AW-1:0]];
      rptr_d = rptr_q + PTR_ONE;
    end

    // A full FIFO being popped this cycle still has room for the incoming word.
    if (push_req) begin
      if (!fifo_full || pop) begin
        mem_d[wptr_q[AW-1:0]] = demodulated;
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (falling) begin
      lrclk_d = (b_d >= SLOT);
      k       = lrclk_d ? (b_d - SLOT) : b_d;
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (k <= BW'(15)) sdata_d = held_d[4'(BW'(15) - k)];
      else              sdata_d = 1'b0;
`else
      if (k >= BW'(1) && k <= BW'(16)) sdata_d = held_d[4'(BW'(16) - k)];
      else                             sdata_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      edge_prev_q <= 1'b0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      b_q         <= '0;
      held_q      <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      edge_prev_q <= edge_prev_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      b_q         <= b_d;
      held_q      <= held_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: reset, timing, data framing, sync latency, overflow, simultaneous push/pop.
module tb_audio_i2s_tx;
  logic        clk_s = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_a = 1'b0;
  logic [15:0] demodulated = '0;
  logic        bclk, lrclk, sdata, overflow, underflow;

  int n_cmp = 0;
  int n_fail = 0;

  audio_i2s_tx #(.HALF_DIV(2), .SLOT_BITS(32), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_s(clk_s), .reset_n(reset_n), .clk_a(clk_a), .demodulated(demodulated),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sel 0 = bclk, 1 = lrclk; waits for the requested edge, sampled on clk_s negedges
  task automatic wait_sig(input int sel, input bit rising, output int cycles, output logic bprev);
    logic prev, cur;
    cycles = 0;
    prev   = (sel == 0) ? bclk : lrclk;
    bprev  = bclk;
    forever begin
      logic bc_before;
      bc_before = bclk;
      @(negedge clk_s);
      cycles++;
      cur = (sel == 0) ? bclk : lrclk;
      if ((rising && !prev && cur) || (!rising && prev && !cur)) begin
        bprev = bc_before;
        return;
      end
      prev = cur;
      if (cycles > 1000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL edge_timeout: observed no edge on sel=%0d after %0d cycles, required one", sel, cycles);
        cycles = -1;
        return;
      end
    end
  endtask

  task automatic get_frame(input string tag, output logic [63:0] raw);
    int c;
    logic bp;
    raw = '0;
    wait_sig(1, 1'b0, c, bp);
    for (int i = 0; i < 64; i++) begin
      wait_sig(0, 1'b1, c, bp);
      raw[i] = sdata;
    end
    $display("frame %s: raw=%h underflow=%b overflow=%b", tag, raw, underflow, overflow);
  endtask

  task automatic push(input logic [15:0] s);
    demodulated = s;
    clk_a = 1'b1;
    repeat (4) @(negedge clk_s);
    clk_a = 1'b0;
    repeat (4) @(negedge clk_s);
    $display("push %h", s);
  endtask

  function automatic logic [63:0] exp_frame(input logic [15:0] s);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      f[i]      = s[15-i];
      f[32 + i] = s[15-i];
`else
      f[i + 1]  = s[15-i];
      f[33 + i] = s[15-i];
`endif
    end
    return f;
  endfunction

  initial begin
    int c;
    logic bp;
    logic [63:0] raw;
    logic [63:0] exp8001;
    logic [2:0] w0;

    // Reset state
    repeat (3) @(negedge clk_s);
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd0);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    reset_n = 1'b1;

    // Timing
    wait_sig(0, 1'b1, c, bp);
    wait_sig(0, 1'b1, c, bp);
    chk("bclk_period", 64'(c), 64'd4);
    wait_sig(1, 1'b0, c, bp);
    wait_sig(1, 1'b1, c, bp);
    chk("lr_rise_align", {62'd0, bp, bclk}, 64'b10);
    wait_sig(1, 1'b0, c, bp);
    chk("lr_fall_align", {62'd0, bp, bclk}, 64'b10);
    wait_sig(1, 1'b0, c, bp);
    chk("lrclk_period", 64'(c), 64'd256);

    // Data framing
    wait_sig(1, 1'b0, c, bp);
    repeat (5) @(negedge clk_s);
    push(16'h8001);
`ifdef I2S_LEFT_JUSTIFIED_EN
    exp8001 = 64'h0000_8001_0000_8001;
`else
    exp8001 = 64'h0001_0002_0001_0002;
`endif
    get_frame("data_8001", raw);
    chk("data_8001", raw, exp8001);

    // Sync latency and single-cycle pulse
    wait_sig(1, 1'b0, c, bp);
    repeat (5) @(negedge clk_s);
    w0 = dut.wptr_q;
    demodulated = 16'h1111;
    clk_a = 1'b1;
    repeat (2) @(negedge clk_s);
    chk("sync_lat_early", 64'(dut.wptr_q), 64'(w0));
    @(negedge clk_s);
    chk("sync_lat_push", 64'(dut.wptr_q), 64'(3'(w0 + 3'd1)));
    repeat (3) @(negedge clk_s);
    clk_a = 1'b0;
    repeat (4) @(negedge clk_s);
    w0 = dut.wptr_q;
    demodulated = 16'h2222;
    clk_a = 1'b1;
    @(negedge clk_s);
    clk_a = 1'b0;
    repeat (8) @(negedge clk_s);
    chk("pulse_one_push", 64'(dut.wptr_q), 64'(3'(w0 + 3'd1)));
    push(16'h3333);

    // Reset mid-frame with three queued samples
    repeat (120) @(negedge clk_s);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bclk", 64'(bclk), 64'd0);
    chk("mid_rst_lrclk", 64'(lrclk), 64'd0);
    chk("mid_rst_sdata", 64'(sdata), 64'd0);
    chk("mid_rst_unf", 64'(underflow), 64'd0);
    repeat (10) @(negedge clk_s);
    reset_n = 1'b1;
    chk("post_rst_unf", 64'(underflow), 64'd0);
    get_frame("post_rst_1", raw);
    chk("post_rst_frame1", raw, 64'd0);
    chk("post_rst_unf1", 64'(underflow), 64'd1);
    get_frame("post_rst_2", raw);
    chk("post_rst_frame2", raw, 64'd0);

    // Overflow
    reset_n = 1'b0;
    repeat (3) @(negedge clk_s);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      get_frame("ovf", raw);
      chk("ovf_frame", raw, exp_frame(16'(i)));
    end
    chk("ovf_unf_before", 64'(underflow), 64'd0);
    get_frame("ovf_5", raw);
    chk("ovf_frame5_repeat", raw, exp_frame(16'h0004));
    chk("ovf_unf_after", 64'(underflow), 64'd1);

    // Push to a full FIFO on the frame-start pop cycle
    reset_n = 1'b0;
    repeat (3) @(negedge clk_s);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'hA000 + 16'(i));
    chk("sim_ovf_fill", 64'(overflow), 64'd0);
    wait_sig(1, 1'b0, c, bp);
    push(16'hA005);
    repeat (245) @(negedge clk_s);
    demodulated = 16'hA006;
    clk_a = 1'b1;
    get_frame("sim_2", raw);
    clk_a = 1'b0;
    chk("sim_frame_a002", raw, exp_frame(16'hA002));
    chk("sim_ovf_clear", 64'(overflow), 64'd0);
    for (int i = 3; i <= 6; i++) begin
      get_frame("sim", raw);
      chk("sim_frame", raw, exp_frame(16'hA000 + 16'(i)));
    end
    chk("sim_unf_before", 64'(underflow), 64'd0);
    chk("sim_ovf_end", 64'(overflow), 64'd0);
    get_frame("sim_last", raw);
    chk("sim_frame_repeat", raw, exp_frame(16'hA006));
    chk("sim_unf_after", 64'(underflow), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
